// File: rtl/view_controller_pkg.sv
// view_controller_pkg
//   Shared board geometry, coordinate type, direction vector and repeat-FSM
//   state encoding used by the view controller and its per-axis stepper.
//   No ports; imported with `import view_controller_pkg::*;`.
package view_controller_pkg;

  localparam int LOG_BOARD_SIZE = 6;
  localparam int BOARD_SIZE     = 1 << LOG_BOARD_SIZE;
  localparam int LOG_VIEW_SIZE  = 4;
  localparam int VIEW_SIZE      = 1 << LOG_VIEW_SIZE;

  // Board coordinate; natural wrap of this width gives the toroidal board.
  typedef logic [LOG_BOARD_SIZE-1:0] pos_t;

  // Sampled direction buttons, MSB first: up, down, left, right.
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  // Reduces an opposing button pair to {move, negative}. Both or neither
  // pressed means no motion on that axis.
  function automatic logic [1:0] axis_delta(input logic pos_btn, input logic neg_btn);
    logic [1:0] d;
    d = {pos_btn ^ neg_btn, neg_btn & ~pos_btn};
    return d;
  endfunction

endpackage

// File: rtl/view_controller_if.sv
// view_controller_if
//   Groups the button inputs, the cursor/view position outputs and the edit
//   request handshake of view_controller.
//   slave  : the controller side (buttons and edit_ready_in in, positions and
//            edit request out).
//   master : the environment side (drives buttons and edit_ready_in).
interface view_controller_if;
  import view_controller_pkg::*;

  logic up_in;
  logic down_in;
  logic left_in;
  logic right_in;
  logic toggle_in;

  pos_t cursor_x_out;
  pos_t cursor_y_out;
  pos_t view_x_out;
  pos_t view_y_out;

  logic edit_valid_out;
  pos_t edit_x_out;
  pos_t edit_y_out;
  logic edit_ready_in;

  modport slave (
    input  up_in, down_in, left_in, right_in, toggle_in, edit_ready_in,
    output cursor_x_out, cursor_y_out, view_x_out, view_y_out,
    output edit_valid_out, edit_x_out, edit_y_out
  );

  modport master (
    output up_in, down_in, left_in, right_in, toggle_in, edit_ready_in,
    input  cursor_x_out, cursor_y_out, view_x_out, view_y_out,
    input  edit_valid_out, edit_x_out, edit_y_out
  );

endinterface

// File: rtl/view_controller_axis_step.sv
// axis_step
//   Purely combinational single-axis stepper. Moves the cursor by -1/0/+1
//   modulo BOARD_SIZE and drags the view window by one cell when the cursor
//   would otherwise leave it.
//   pos_in/view_in   : current cursor and view origin on this axis
//   step_in/neg_in   : move this cycle / move in the negative direction
//   pos_out/view_out : next cursor and view origin
module axis_step
  import view_controller_pkg::*;
(
  input  pos_t pos_in,
  input  pos_t view_in,
  input  logic step_in,
  input  logic neg_in,
  output pos_t pos_out,
  output pos_t view_out
);

  localparam pos_t ONE       = pos_t'(1);
  // Offsets just outside the window on each side (-1 wraps to all ones).
  localparam pos_t OFF_OVER  = pos_t'(VIEW_SIZE);
  localparam pos_t OFF_UNDER = pos_t'(BOARD_SIZE - 1);

  pos_t pos_next_s;
  pos_t off_s;

  // Next cursor position and view origin for this axis.
  always_comb begin
    pos_next_s = pos_in;
    off_s      = pos_in - view_in;
    pos_out    = pos_in;
    view_out   = view_in;
    if (step_in) begin
      if (neg_in) begin
        pos_next_s = pos_in - ONE;
      end else begin
        pos_next_s = pos_in + ONE;
      end
      off_s   = pos_next_s - view_in;
      pos_out = pos_next_s;
      // Only one cell of motion per step, so the view never needs more than
      // one cell of correction to keep the cursor inside.
      if (off_s == OFF_OVER) begin
        view_out = view_in + ONE;
      end else if (off_s == OFF_UNDER) begin
        view_out = view_in - ONE;
      end else begin
        view_out = view_in;
      end
    end else begin
      pos_out  = pos_in;
      view_out = view_in;
    end
  end

endmodule

// File: rtl/view_controller.sv
// view_controller
//   Converts debounced button levels into cursor / view-window positions for
//   the renderer and into single-cell toggle requests for the board memory.
//   Held directions auto-repeat after REPEAT_DELAY cycles, then every
//   REPEAT_PERIOD cycles. All outputs are registered.
//   clk_130mhz : system clock (shared with the renderer)
//   rst_in     : synchronous active-high reset
//   bus        : buttons in, cursor/view out, edit valid/ready handshake
module view_controller
  import view_controller_pkg::*;
#(
  parameter int REPEAT_DELAY  = 52_000_000,
  parameter int REPEAT_PERIOD = 13_000_000
) (
  input  logic              clk_130mhz,
  input  logic              rst_in,
  view_controller_if.slave  bus
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DELAY_LOAD  = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t PERIOD_LOAD = cnt_t'(REPEAT_PERIOD - 1);
  localparam cnt_t CNT_ZERO    = cnt_t'(0);
  localparam cnt_t CNT_ONE     = cnt_t'(1);

  repeat_state_t state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  dir_t          prev_dir_q, prev_dir_d;
  logic          toggle_prev_q, toggle_prev_d;
  pos_t          cursor_x_q, cursor_x_d;
  pos_t          cursor_y_q, cursor_y_d;
  pos_t          view_x_q, view_x_d;
  pos_t          view_y_q, view_y_d;
  logic          edit_valid_q, edit_valid_d;
  pos_t          edit_x_q, edit_x_d;
  pos_t          edit_y_q, edit_y_d;

  dir_t       dir_s;
  logic       dir_any_s;
  logic       step_s;
  logic [1:0] x_delta_s;
  logic [1:0] y_delta_s;
  logic       accept_s;
  logic       toggle_rise_s;

  assign dir_s     = {bus.up_in, bus.down_in, bus.left_in, bus.right_in};
  assign dir_any_s = |dir_s;
  assign x_delta_s = axis_delta(dir_s.right, dir_s.left);
  assign y_delta_s = axis_delta(dir_s.down, dir_s.up);

  axis_step u_axis_x (
    .pos_in   (cursor_x_q),
    .view_in  (view_x_q),
    .step_in  (step_s & x_delta_s[1]),
    .neg_in   (x_delta_s[0]),
    .pos_out  (cursor_x_d),
    .view_out (view_x_d)
  );

  axis_step u_axis_y (
    .pos_in   (cursor_y_q),
    .view_in  (view_y_q),
    .step_in  (step_s & y_delta_s[1]),
    .neg_in   (y_delta_s[0]),
    .pos_out  (cursor_y_d),
    .view_out (view_y_d)
  );

  // Auto-repeat FSM: decides when a step fires and reloads the hold counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dir_any_s) begin
          step_s  = 1'b1;
          cnt_d   = DELAY_LOAD;
          state_d = DELAY;
        end else begin
          state_d = IDLE;
        end
      end
      DELAY, REPEAT: begin
        if (!dir_any_s) begin
          state_d = IDLE;
        end else if (dir_s != prev_dir_q) begin
          // A changed combination restarts the initial delay.
          step_s  = 1'b1;
          cnt_d   = DELAY_LOAD;
          state_d = DELAY;
        end else if (cnt_q == CNT_ZERO) begin
          step_s  = 1'b1;
          cnt_d   = PERIOD_LOAD;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Edge history for direction-change and toggle-edge detection.
  always_comb begin
    prev_dir_d    = dir_s;
    toggle_prev_d = bus.toggle_in;
  end

  // Edit request: latch the pre-step cursor on a toggle edge when the slot is
  // free or being freed by this cycle's handshake; otherwise the edge is lost.
  always_comb begin
    edit_valid_d  = edit_valid_q;
    edit_x_d      = edit_x_q;
    edit_y_d      = edit_y_q;
    accept_s      = edit_valid_q & bus.edit_ready_in;
    toggle_rise_s = bus.toggle_in & ~toggle_prev_q;
    if (toggle_rise_s && (!edit_valid_q || accept_s)) begin
      edit_valid_d = 1'b1;
      edit_x_d     = cursor_x_q;
      edit_y_d     = cursor_y_q;
    end else if (accept_s) begin
      edit_valid_d = 1'b0;
    end else begin
      edit_valid_d = edit_valid_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_130mhz) begin
    if (rst_in) begin
      state_q       <= IDLE;
      cnt_q         <= CNT_ZERO;
      prev_dir_q    <= dir_t'(4'b0000);
      toggle_prev_q <= 1'b0;
      cursor_x_q    <= pos_t'(0);
      cursor_y_q    <= pos_t'(0);
      view_x_q      <= pos_t'(0);
      view_y_q      <= pos_t'(0);
      edit_valid_q  <= 1'b0;
      edit_x_q      <= pos_t'(0);
      edit_y_q      <= pos_t'(0);
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_dir_q    <= prev_dir_d;
      toggle_prev_q <= toggle_prev_d;
      cursor_x_q    <= cursor_x_d;
      cursor_y_q    <= cursor_y_d;
      view_x_q      <= view_x_d;
      view_y_q      <= view_y_d;
      edit_valid_q  <= edit_valid_d;
      edit_x_q      <= edit_x_d;
      edit_y_q      <= edit_y_d;
    end
  end

  assign bus.cursor_x_out   = cursor_x_q;
  assign bus.cursor_y_out   = cursor_y_q;
  assign bus.view_x_out     = view_x_q;
  assign bus.view_y_out     = view_y_q;
  assign bus.edit_valid_out = edit_valid_q;
  assign bus.edit_x_out     = edit_x_q;
  assign bus.edit_y_out     = edit_y_q;

endmodule

// File: tb/tb_view_controller.sv
// tb_view_controller
//   Drives directed and random button sequences into view_controller and
//   checks every cycle's outputs against a reference model that works from
//   hold durations and window membership rather than from the FSM.
module tb_view_controller;
  import view_controller_pkg::*;

  localparam int RD = 4;
  localparam int RP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  view_controller_if bus ();

  view_controller #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk_130mhz (clk),
    .rst_in     (rst),
    .bus        (bus)
  );

  typedef struct {
    int cx, cy, vx, vy;
    bit ev;
    int ex, ey;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  int m_cx, m_cy, m_vx, m_vy;
  bit m_ev;
  int m_ex, m_ey;
  logic [3:0] m_prev_dir;
  int m_hold;
  bit m_prev_tog;

  int vectors = 0;
  int miscompares = 0;

  function automatic int wrap(input int v);
    return ((v % BOARD_SIZE) + BOARD_SIZE) % BOARD_SIZE;
  endfunction

  // Move one axis; if the cursor falls outside [view, view+VIEW_SIZE-1]
  // (mod board), shift the view by one cell toward it.
  task automatic move_axis(inout int c, inout int v, input int d);
    int off;
    c = wrap(c + d);
    off = wrap(c - v);
    if (d != 0 && off >= VIEW_SIZE) begin
      if (off == VIEW_SIZE) v = wrap(v + 1);
      else v = wrap(v - 1);
    end
  endtask

  task automatic model_step(input bit r, input logic [3:0] d, input bit tog, input bit rdy);
    exp_t e;
    bit accepted, rise, fire;
    int dx, dy;
    if (r) begin
      m_cx = 0; m_cy = 0; m_vx = 0; m_vy = 0;
      m_ev = 0; m_ex = 0; m_ey = 0;
      m_prev_dir = 4'b0000; m_hold = -1; m_prev_tog = 0;
    end else begin
      accepted = m_ev && rdy;
      rise = tog && !m_prev_tog;
      if (rise && (!m_ev || accepted)) begin
        m_ev = 1; m_ex = m_cx; m_ey = m_cy;
      end else if (accepted) begin
        m_ev = 0;
      end
      if (d == 4'b0000) m_hold = -1;
      else if (d == m_prev_dir) m_hold = m_hold + 1;
      else m_hold = 0;
      fire = (d != 4'b0000) &&
             (m_hold == 0 || m_hold == RD || (m_hold > RD && ((m_hold - RD) % RP) == 0));
      if (fire) begin
        dx = int'(d[0]) - int'(d[1]);
        dy = int'(d[2]) - int'(d[3]);
        move_axis(m_cx, m_vx, dx);
        move_axis(m_cy, m_vy, dy);
      end
      m_prev_dir = d;
      m_prev_tog = tog;
    end
    e.cx = m_cx; e.cy = m_cy; e.vx = m_vx; e.vy = m_vy;
    e.ev = m_ev; e.ex = m_ex; e.ey = m_ey;
    exp_q.push_back(e);
  endtask

  // d = {up, down, left, right}
  task automatic drive(input bit r, input logic [3:0] d, input bit tog, input bit rdy);
    @(negedge clk);
    rst = r;
    bus.up_in = d[3];
    bus.down_in = d[2];
    bus.left_in = d[1];
    bus.right_in = d[0];
    bus.toggle_in = tog;
    bus.edit_ready_in = rdy;
    model_step(r, d, tog, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, d, 1'b0, 1'b0);
      drive(1'b0, 4'b0000, 1'b0, 1'b0);
    end
  endtask

  task automatic hold(input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 4'b0000, 1'b0, 1'b0);
  endtask

  // Monitor: compare the registered outputs just after every active edge
  // against the oldest outstanding expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (int'(bus.cursor_x_out) != e.cx || int'(bus.cursor_y_out) != e.cy ||
          int'(bus.view_x_out) != e.vx || int'(bus.view_y_out) != e.vy ||
          bus.edit_valid_out !== e.ev ||
          int'(bus.edit_x_out) != e.ex || int'(bus.edit_y_out) != e.ey) begin
        miscompares++;
        $display("FAIL outputs @%0t: got cur=(%0d,%0d) view=(%0d,%0d) edit=%0b(%0d,%0d) exp cur=(%0d,%0d) view=(%0d,%0d) edit=%0b(%0d,%0d)",
                 $time, bus.cursor_x_out, bus.cursor_y_out, bus.view_x_out, bus.view_y_out,
                 bus.edit_valid_out, bus.edit_x_out, bus.edit_y_out,
                 e.cx, e.cy, e.vx, e.vy, e.ev, e.ex, e.ey);
      end
    end
  end

  initial begin
    logic [3:0] d;
    bit tog, rdy;
    bus.up_in = 1'b0; bus.down_in = 1'b0; bus.left_in = 1'b0; bus.right_in = 1'b0;
    bus.toggle_in = 1'b0; bus.edit_ready_in = 1'b0;

    // Reset, single right pulse, then quiet.
    do_reset(3);
    pulse(4'b0001, 1);
    idle(5);

    // Right held 10 cycles: steps at k, k+4, k+6, k+8.
    do_reset(1);
    hold(4'b0001, 10);
    idle(3);

    // Left from origin wraps cursor and view.
    do_reset(1);
    pulse(4'b0010, 1);
    idle(2);

    // Down pulses until the view first scrolls, and a bit beyond.
    do_reset(1);
    pulse(4'b0100, VIEW_SIZE + 2);

    // Diagonal up+left, then up+down+right (x only).
    hold(4'b1010, 10);
    idle(2);
    hold(4'b1101, 10);
    idle(2);

    // Edit handshake: toggle at (3,5) with ready low, move, toggle again.
    do_reset(1);
    pulse(4'b0001, 3);
    pulse(4'b0100, 5);
    drive(1'b0, 4'b0000, 1'b1, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 1'b0);
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    pulse(4'b0001, 2);
    drive(1'b0, 4'b0000, 1'b1, 1'b0);
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    idle(3);
    // Toggle edge on the same cycle the pending request is accepted.
    drive(1'b0, 4'b0000, 1'b1, 1'b0);
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    idle(2);

    // Button held through reset acts on the first cycle after it.
    do_reset(1);
    drive(1'b1, 4'b0101, 1'b1, 1'b0);
    drive(1'b0, 4'b0101, 1'b1, 1'b0);
    idle(2);

    // Randomised phase with persistent buttons.
    d = 4'b0000; tog = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) tog = ~tog;
      rdy = ($urandom_range(0, 3) == 0);
      drive(($urandom_range(0, 599) == 0), d, tog, rdy);
    end
    idle(2);

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d outstanding expectations, need 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/view_controller.md
# view_controller

Turns debounced button levels into the cursor and view-window positions consumed by the renderer, and into single-cell toggle requests for the board-memory write path. It sits upstream of the renderer and drives its `cursor_x_in`/`cursor_y_in`/`view_x_in`/`view_y_in`. Held direction buttons auto-repeat. The view scrolls so that the cursor never leaves the visible window. The board is toroidal.

## Interface
- `REPEAT_DELAY`, default 52_000_000: cycles a direction must be held before the first auto-repeat (0.4 s at 130 MHz); must be ≥1.
- `REPEAT_PERIOD`, default 13_000_000: cycles between subsequent repeats; must be ≥1.
- `clk_130mhz` in 1: system clock, the same clock as the renderer.
- `rst_in` in 1: synchronous, active-high reset.
- `up_in`, `down_in`, `left_in`, `right_in` in 1 each: debounced, level, active-high direction buttons.
- `toggle_in` in 1: debounced, level, active-high edit button.
- `cursor_x_out`, `cursor_y_out` out LOG_BOARD_SIZE each: cursor position in board coordinates.
- `view_x_out`, `view_y_out` out LOG_BOARD_SIZE each: top-left board cell of the view window.
- `edit_valid_out` out 1: a toggle request is pending.
- `edit_x_out`, `edit_y_out` out LOG_BOARD_SIZE each: cell to toggle; stable while `edit_valid_out` is high.
- `edit_ready_in` in 1: the consumer accepts the request in a cycle where both `edit_valid_out` and `edit_ready_in` are high.

## Operation
- **Direction vector:** dir = {up, down, left, right} is sampled each cycle.
  - Up and down both high: no vertical motion.
  - Left and right both high: no horizontal motion.
  - A diagonal moves both axes in the same step.
- **Step:** x += (right − left), y += (down − up).
  - Arithmetic is modulo BOARD_SIZE (natural LOG_BOARD_SIZE-bit wrap), so 0 − 1 → BOARD_SIZE − 1.
- **View follow:** the offset is off = (cursor − view) mod BOARD_SIZE, computed per axis.
  - Invariant: off ∈ [0, VIEW_SIZE − 1] at all times.
  - A step that would make off = VIEW_SIZE moves the view by +1 on that axis.
  - A step that would make off = BOARD_SIZE − 1 (i.e. −1) moves the view by −1 on that axis.
  - The view update lands in the same cycle as the cursor update.
- **Repeat FSM, states IDLE / DELAY / REPEAT; one down-counter of $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)) bits:**
  - IDLE, dir ≠ 0: step, load counter with REPEAT_DELAY − 1, go to DELAY.
  - DELAY or REPEAT, dir == 0: go to IDLE, no step.
  - DELAY or REPEAT, dir ≠ 0 but different from the previous cycle's dir: treat as a new press (step, load REPEAT_DELAY − 1, go to DELAY).
  - DELAY or REPEAT, counter == 0 and dir unchanged: step, load REPEAT_PERIOD − 1, go to REPEAT.
  - Otherwise: decrement the counter.
- **Edit:** a rising edge of `toggle_in` while `edit_valid_out` is low latches the current (pre-step) cursor into `edit_x_out`/`edit_y_out` and sets `edit_valid_out`.
  - A rising edge while a request is pending is dropped; there is no queue.
  - Handshake: `edit_valid_out` clears on the clock edge after the cycle with valid && ready.
  - A new request may be latched on that same clearing edge.
  - Cursor motion while a request is pending does not alter `edit_x_out`/`edit_y_out`.
- **Reset:**
  - Cursor and view are both (0,0).
  - `edit_valid_out` = 0, `edit_x_out`/`edit_y_out` = 0, FSM in IDLE, counter 0.
  - The previous-dir and previous-toggle registers are 0, so a button held through reset produces a step or edit on the first cycle after reset.
  - Reset in the middle of a repeat or a pending edit abandons it.

## Timing
- All outputs are registered.
- A press sampled at edge k is visible on the cursor/view outputs after edge k (one-cycle latency).
- Holding a direction from edge k produces steps at edges k, k+REPEAT_DELAY, and then every REPEAT_PERIOD.
- A toggle edge sampled at edge k gives `edit_valid_out` high after edge k.
- The renderer samples these outputs during vsync, so changes in mid-frame are safe; no frame handshake is needed.

## Structure
- BOARD_SIZE, LOG_BOARD_SIZE, VIEW_SIZE, LOG_VIEW_SIZE and `pos_t` come from the shared `common.svh`.
- Add to `common.svh`: `dir_t` (a 4-bit packed struct up/down/left/right) and `repeat_state_t` (enum IDLE, DELAY, REPEAT).
- One sub-module, `axis_step`, is instantiated twice (x and y).
  - Function: given pos, view, and a −1/0/+1 delta, it returns the next pos and next view (view-follow logic).
  - It is purely combinational and owns the modulo arithmetic.

## Test plan
Benches use REPEAT_DELAY = 4, REPEAT_PERIOD = 2, and VIEW_SIZE and BOARD_SIZE from `common.svh`.
- Reset, then a single-cycle `right_in` pulse → cursor (1,0), view (0,0); no further change while the button is released.
- `right_in` held for 10 cycles from edge k → steps at k, k+4, k+6 and k+8, giving cursor_x = 4.
- From cursor (0,0), view (0,0), pulse `left_in` → cursor_x = BOARD_SIZE − 1 and view_x = BOARD_SIZE − 1.
- Repeated single pulses of `down_in` until cursor_y = VIEW_SIZE → view_y becomes 1 on exactly that step; before it, view_y stays 0.
- Up+left held together → both axes step on the same edges; up+down+right held → only x steps.
- Toggle pressed at cursor (3,5) with `edit_ready_in` low, cursor then moved, then a second toggle → `edit_valid_out` stays high with edit = (3,5); second toggle dropped. Raise ready for one cycle → valid clears on the next edge.
